y_event_counter: RTL and testbench

Downstream consumer of the single-bit output `y` of the combinational decode stage `b`. It counts rising edges of `y` over a programmable window of clock cycles, then presents the count on a valid/ready output port. It is the first sequential stage after `b` and turns its level output into a per-window event count for the reporting logic.

---
 rtl/y_event_pkg.sv | 19 +
 rtl/y_sync_edge.sv | 43 ++++
 rtl/y_event_counter.sv | 96 +++++++++
 tb/tb_y_event_counter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y_event_pkg.sv
// y_event_pkg: state type and default sizing shared by the y event counter.
// Imported by y_sync_edge and y_event_counter.
package y_event_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_REPORT = 2'd2
   } y_event_state_t;

   localparam int unsigned Y_EVENT_WINDOW_DEF = 16;
   localparam int unsigned Y_EVENT_CNT_W_DEF  = 8;

   // timer must hold WINDOW-1; a one-cycle window still needs one bit
   function automatic int unsigned timer_width(int unsigned win);
      return (win > 1) ? $clog2(win) : 1;
   endfunction

endpackage

// File: rtl/y_sync_edge.sv
// y_sync_edge: optional two-flop input synchronizer, one-cycle delay y_d and
// rising-edge pulse. Y_EVENT_SYNC_EN selects the synchronized input path.
module y_sync_edge
   import y_event_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic y_i,
   output logic edge_o
);

   logic y_s;
   logic y_d_q;

`ifdef Y_EVENT_SYNC_EN
   logic [1:0] sync_q;

   // two-flop synchronizer; y_s is the second stage
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], y_i};
      end
   end

   assign y_s = sync_q[1];
`else
   assign y_s = y_i;
`endif

   // previous sample; runs in every FSM state so a pre-window high is no edge
   always_ff @(posedge clk) begin
      if (rst) begin
         y_d_q <= 1'b0;
      end else begin
         y_d_q <= y_s;
      end
   end

   assign edge_o = y_s & ~y_d_q;

endmodule

// File: rtl/y_event_counter.sv
// y_event_counter: counts rising edges of y over a WINDOW-cycle window and
// reports the count on a valid/ready port. Input sync via Y_EVENT_SYNC_EN.
module y_event_counter
   import y_event_pkg::*;
#(
   parameter int unsigned WINDOW = Y_EVENT_WINDOW_DEF,
   parameter int unsigned CNT_W  = Y_EVENT_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             y_in,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             ovf
);

   localparam int unsigned      TW       = timer_width(WINDOW);
   localparam logic [TW-1:0]    TMR_LOAD = TW'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   y_event_state_t   state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             y_edge;

   y_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .y_i    (y_in),
      .edge_o (y_edge)
   );

   // state, window timer, count and sticky overflow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // next state, timer countdown and saturating edge count
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_COUNT;
               tmr_d   = TMR_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_COUNT: begin
            if (y_edge) begin
               if (cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            tmr_d = tmr_q - 1'b1;
            if (tmr_q == '0) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (cnt_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign cnt_valid = (state_q == ST_REPORT);
   assign cnt_out   = cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_y_event_counter.sv
// tb_y_event_counter: scoreboard bench for y_event_counter in three sizings.
// Works with or without Y_EVENT_SYNC_EN defined.
module tb_y_event_counter;

   typedef struct {
      int id;
      int cnt;
      int ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       y_in;
   logic       cnt_ready;
   logic [2:0] start_v;
   logic [2:0] busy_v;
   logic [2:0] vld_v;
   logic [2:0] ovf_v;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt2;
   logic [7:0] cnt_a [3];

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   assign cnt_a[0] = cnt0;
   assign cnt_a[1] = {6'b0, cnt1};
   assign cnt_a[2] = cnt2;

   y_event_counter u_dut (
      .clk       (clk),
      .rst       (rst),
      .y_in      (y_in),
      .start     (start_v[0]),
      .busy      (busy_v[0]),
      .cnt_out   (cnt0),
      .cnt_valid (vld_v[0]),
      .cnt_ready (cnt_ready),
      .ovf       (ovf_v[0])
   );

   y_event_counter #(.WINDOW(16), .CNT_W(2)) u_sat (
      .clk       (clk),
      .rst       (rst),
      .y_in      (y_in),
      .start     (start_v[1]),
      .busy      (busy_v[1]),
      .cnt_out   (cnt1),
      .cnt_valid (vld_v[1]),
      .cnt_ready (cnt_ready),
      .ovf       (ovf_v[1])
   );

   y_event_counter #(.WINDOW(1), .CNT_W(8)) u_w1 (
      .clk       (clk),
      .rst       (rst),
      .y_in      (y_in),
      .start     (start_v[2]),
      .busy      (busy_v[2]),
      .cnt_out   (cnt2),
      .cnt_valid (vld_v[2]),
      .cnt_ready (cnt_ready),
      .ovf       (ovf_v[2])
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(int id, logic [31:0] pat, int len,
                                  logic prev, int cw);
      exp_t e;
      int   mx;
      logic p;
      e.id  = id;
      e.cnt = 0;
      e.ovf = 0;
      mx    = (1 << cw) - 1;
      p     = prev;
      for (int i = 0; i < len; i++) begin
         if (pat[i] && !p) begin
            if (e.cnt == mx) e.ovf = 1;
            else e.cnt++;
         end
         p = pat[i];
      end
      return e;
   endfunction

   task automatic run_window(input int id, input logic [31:0] pat,
                             input int w, input logic prev, input int cw,
                             output exp_t e);
      int lat;
      bit early;
      e = model(id, pat, w, prev, cw);
      sb_q.push_back(e);
      start_v[id] = 1'b1;
      tick();
      start_v[id] = 1'b0;
      lat = 1;
      early = 1'b0;
      chk("busy_on", busy_v[id], 1);
      for (int i = 0; i < w; i++) begin
         y_in = pat[i];
         if (vld_v[id]) early = 1'b1;
         tick();
         lat++;
      end
      y_in = 1'b0;
      while (!vld_v[id] && lat < w + 40) begin
         tick();
         lat++;
      end
      chk("early_valid", early, 0);
      chk("latency", lat, w + 1);
      chk("valid", vld_v[id], 1);
   endtask

   task automatic drain(input int id);
      tick();
      chk("post_hs_valid", vld_v[id], 0);
      chk("post_hs_busy", busy_v[id], 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (vld_v[i] && cnt_ready) begin
               if (sb_q.size() == 0) begin
                  chk("sb_empty", 1, 0);
               end else begin
                  mon_e = sb_q.pop_front();
                  chk("sb_id", i, mon_e.id);
                  chk("cnt_out", cnt_a[i], mon_e.cnt);
                  chk("ovf", ovf_v[i], mon_e.ovf);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   k;
      rst = 1'b1;
      y_in = 1'b0;
      cnt_ready = 1'b1;
      start_v = '0;
      repeat (3) tick();
      chk("rst_busy", busy_v[0], 0);
      chk("rst_valid", vld_v[0], 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_ovf", ovf_v[0], 0);
      rst = 1'b0;
      repeat (3) tick();

      run_window(0, 32'b0110_1101_1011_0110, 16, 1'b0, 8, e);
      drain(0);
      repeat (2) tick();

      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         y_in = (i == 1 || i == 4 || i == 7);
         tick();
      end
      y_in = 1'b0;
      chk("mid_busy", busy_v[0], 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", busy_v[0], 0);
      chk("mid_rst_cnt", cnt0, 0);
      chk("mid_rst_valid", vld_v[0], 0);
      chk("mid_rst_ovf", ovf_v[0], 0);
      repeat (3) tick();

      run_window(0, 32'h0000_0318, 16, 1'b0, 8, e);
      drain(0);

      y_in = 1'b1;
      repeat (4) tick();
      run_window(0, 32'h0000_FFFF, 16, 1'b1, 8, e);
      drain(0);
      repeat (3) tick();

      run_window(1, 32'h0000_1554, 16, 1'b0, 2, e);
      drain(1);
      repeat (3) tick();

`ifdef Y_EVENT_SYNC_EN
      run_window(2, 32'h0000_0000, 1, 1'b0, 8, e);
`else
      run_window(2, 32'h0000_0001, 1, 1'b0, 8, e);
`endif
      drain(2);
      repeat (3) tick();

      cnt_ready = 1'b0;
      run_window(0, 32'h0000_00D8, 16, 1'b0, 8, e);
      for (int i = 0; i < 10; i++) begin
         y_in = (i < 8) ? i[0] : 1'b0;
         start_v[0] = (i % 3 == 0);
         tick();
         chk("hold_cnt", cnt0, e.cnt);
         chk("hold_valid", vld_v[0], 1);
         chk("hold_busy", busy_v[0], 1);
      end
      y_in = 1'b0;
      start_v[0] = 1'b1;
      cnt_ready = 1'b1;
      tick();
      chk("hs_valid", vld_v[0], 0);
      chk("hs_busy", busy_v[0], 0);
      sb_q.push_back(model(0, 32'h0, 16, 1'b0, 8));
      tick();
      start_v[0] = 1'b0;
      chk("restart_busy", busy_v[0], 1);
      k = 0;
      while (!vld_v[0] && k < 40) begin
         tick();
         k++;
      end
      chk("restart_lat", k, 16);
      drain(0);
      repeat (2) tick();

      chk("sb_left", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
